clause_dispatch_ctrl: RTL and testbench

//  Sequences one BCP pass: streams clauses from the clause memory into a small

---
 rtl/clause_dispatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_clause_dispatch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_dispatch_ctrl.sv
// ============================================================================
// clause_dispatch_ctrl - one BCP pass: clause memory -> multi-pop FIFO -> arbiter
// rev 1.0
// ============================================================================
`default_nettype none

module clause_dispatch_ctrl #(
    parameter  int NUM_ENGINE    = 4,
    parameter  int CLA_LENGTH    = 3,
    parameter  int LIT_INDEX_MAX = 16,
    parameter  int MEM_DEPTH     = 64,
    parameter  int FIFO_DEPTH    = 8,
    localparam int CNT_W         = $clog2(NUM_ENGINE) + 1,
    localparam int EL_W          = $clog2(LIT_INDEX_MAX) + 1,
    localparam int CLA_W         = CLA_LENGTH * EL_W,
    localparam int AW            = $clog2(MEM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [AW:0]                 num_clauses_i,
    output logic                        mem_rd_en_o,
    output logic [AW-1:0]               mem_rd_addr_o,
    input  logic [CLA_W-1:0]            mem_rd_data_i,
    output logic [NUM_ENGINE*CLA_W-1:0] clause_out_o,
    output logic [CNT_W-1:0]            clause_cnt_out_o,
    input  logic [CNT_W-1:0]            clause_accept_in_i,
    input  logic [NUM_ENGINE-1:0]       engine_idle_in_i,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DRAIN     = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [AW:0]        num_q, num_d;
    logic [AW:0]        addr_q, addr_d;
    logic               inflight_q;
    logic [PW-1:0]      head_q, tail_q;
    logic [FCW-1:0]     count_q;
    logic [CLA_W-1:0]   fifo_q [FIFO_DEPTH];

    logic [CNT_W-1:0]   cnt_out;
    logic [CNT_W-1:0]   pop;
    logic               rd_en;

    // Credit uses the registered count only, so a pop this cycle never frees
    // a slot for a read issued in the same cycle.
    always_comb begin
        if (count_q > FCW'(NUM_ENGINE)) begin
            cnt_out = CNT_W'(NUM_ENGINE);
        end else begin
            cnt_out = CNT_W'(count_q);
        end
        pop   = (clause_accept_in_i > cnt_out) ? cnt_out : clause_accept_in_i;
        rd_en = (state_q == S_FETCH) && (addr_q < num_q) &&
                (({1'b0, count_q} + {{FCW{1'b0}}, inflight_q}) < (FCW+1)'(FIFO_DEPTH));
    end

    always_comb begin
        clause_out_o = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            if (CNT_W'(k) < cnt_out) begin
                clause_out_o[k*CLA_W +: CLA_W] = fifo_q[head_q + PW'(k)];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_d   = num_clauses_i;
                    addr_d  = '0;
                    state_d = (num_clauses_i == '0) ? S_WAIT_IDLE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_en) begin
                    addr_d = addr_q + (AW+1)'(1);
                    if (addr_d == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && !inflight_q) begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (&engine_idle_in_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (abort_i) begin
            // Clearing inflight drops the data of any read still returning.
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            addr_q     <= addr_d;
            inflight_q <= rd_en;
            head_q     <= head_q + PW'(pop);
            tail_q     <= tail_q + PW'(inflight_q);
            count_q    <= count_q + FCW'(inflight_q) - FCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q && !abort_i) begin
            fifo_q[tail_q] <= mem_rd_data_i;
        end
    end

    assign mem_rd_en_o      = rd_en;
    assign mem_rd_addr_o    = addr_q[AW-1:0];
    assign clause_cnt_out_o = cnt_out;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_clause_dispatch_ctrl.sv
// Bench for clause_dispatch_ctrl: vector table, corner sequences and random passes
// checked against an occupancy/ordering model of the dispatch stream.
`timescale 1ns/1ps

module tb_clause_dispatch_ctrl;

    localparam int NE    = 4;
    localparam int CLA_W = 15;
    localparam int AW    = 6;
    localparam int CNT_W = 3;
    localparam int FD    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic                  abort_i = 1'b0;
    logic [AW:0]           num_i = '0;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [CLA_W-1:0]      mem_rd_data = '0;
    logic [NE*CLA_W-1:0]   clause_out;
    logic [CNT_W-1:0]      cnt_out;
    logic [CNT_W-1:0]      accept_i = '0;
    logic [NE-1:0]         idle_i = '1;
    logic                  busy;
    logic                  done;

    logic [CLA_W-1:0]      mem [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    clause_dispatch_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .num_clauses_i      (num_i),
        .mem_rd_en_o        (mem_rd_en),
        .mem_rd_addr_o      (mem_rd_addr),
        .mem_rd_data_i      (mem_rd_data),
        .clause_out_o       (clause_out),
        .clause_cnt_out_o   (cnt_out),
        .clause_accept_in_i (accept_i),
        .engine_idle_in_i   (idle_i),
        .busy_o             (busy),
        .done_o             (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: clauses leave in address order; the FIFO holds what has
    // arrived minus what has been accepted.
    int issued, arrived, pending, n_acc, num_lat, done_cnt;
    bit mon = 0;
    bit in_pass = 0;

    task automatic tick(input int acc, input logic [3:0] idle);
        int cnt_b, occ, exp_cnt;
        bit rd_b;
        logic [NE*CLA_W-1:0] exp_out;
        cnt_b = int'(cnt_out);
        rd_b  = mem_rd_en;
        if (mon && rd_b) chk("rd_addr", 64'(mem_rd_addr), 64'(issued));
        accept_i = CNT_W'(acc);
        idle_i   = idle;
        @(posedge clk); #1;
        if (mon) begin
            n_acc   += (acc > cnt_b) ? cnt_b : acc;
            arrived += pending;
            pending  = rd_b ? 1 : 0;
            if (rd_b) issued++;
            occ     = arrived - n_acc;
            exp_cnt = (occ > NE) ? NE : occ;
            chk("cnt_out", 64'(cnt_out), 64'(exp_cnt));
            exp_out = '0;
            for (int k = 0; k < NE; k++)
                if (k < exp_cnt) exp_out[k*CLA_W +: CLA_W] = mem[n_acc + k];
            chk("slots", 64'(clause_out), 64'(exp_out));
            chk("rd_en", 64'(mem_rd_en), 64'((issued < num_lat) && (occ + pending < FD)));
            if (in_pass) chk("busy_in_pass", 64'(busy), 64'(1));
            if (done) begin
                done_cnt++;
                chk("done_all_taken", 64'(n_acc), 64'(num_lat));
                chk("done_all_read", 64'(issued), 64'(num_lat));
                in_pass = 0;
            end
        end
    endtask

    task automatic start_pass(input int n);
        issued = 0; arrived = 0; pending = 0; n_acc = 0;
        num_lat = n; done_cnt = 0; in_pass = 1; mon = 1;
        start_i = 1'b1;
        num_i   = 7'(n);
        tick(0, 4'hF);
        start_i = 1'b0;
        num_i   = 7'($urandom_range(0, 64));
    endtask

    task automatic run_to_done(input int mode, input int bound);
        int cyc, acc;
        logic [3:0] idle;
        cyc = 0;
        while (in_pass && cyc < bound) begin
            case (mode)
                0:       acc = int'($urandom_range(0, 5));
                1:       acc = 4;
                default: acc = 1;
            endcase
            idle = (mode == 0 && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            tick(acc, idle);
            cyc++;
        end
        chk("pass_finished", 64'(in_pass), 64'(0));
        tick(0, 4'hF);
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_pulses", 64'(done_cnt), 64'(1));
    endtask

    typedef struct {
        logic       start;
        logic [6:0] num;
        logic [3:0] idle;
        logic [2:0] acc;
        logic       busy;
        logic       done;
        logic       rd;
        logic [2:0] cnt;
        int         slot0;
    } vec_t;

    function automatic vec_t mk(input logic s, input int n, input logic [3:0] id, input int a,
                                input logic b, input logic d, input logic r, input int c,
                                input int s0);
        vec_t v;
        v.start = s; v.num = 7'(n); v.idle = id; v.acc = 3'(a);
        v.busy = b; v.done = d; v.rd = r; v.cnt = 3'(c); v.slot0 = s0;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        logic [CLA_W-1:0] s0_exp;
        int waitc;

        for (int i = 0; i < 64; i++) mem[i] = 15'(i * 37 + 5);

        // num_clauses=5, accept 4 every cycle (clamped), then num_clauses=0 with slow engines
        vecs[0]  = mk(1, 5, 4'hF, 4, 1, 0, 1, 0, -1);
        vecs[1]  = mk(0, 9, 4'hF, 4, 1, 0, 1, 0, -1);
        vecs[2]  = mk(0, 9, 4'hF, 4, 1, 0, 1, 1,  0);
        vecs[3]  = mk(0, 9, 4'hF, 4, 1, 0, 1, 1,  1);
        vecs[4]  = mk(0, 9, 4'hF, 4, 1, 0, 1, 1,  2);
        vecs[5]  = mk(0, 9, 4'hF, 4, 1, 0, 0, 1,  3);
        vecs[6]  = mk(1, 9, 4'hF, 4, 1, 0, 0, 1,  4);
        vecs[7]  = mk(0, 9, 4'hF, 4, 1, 0, 0, 0, -1);
        vecs[8]  = mk(0, 9, 4'hF, 4, 1, 0, 0, 0, -1);
        vecs[9]  = mk(0, 9, 4'hF, 4, 1, 1, 0, 0, -1);
        vecs[10] = mk(0, 9, 4'hF, 4, 0, 0, 0, 0, -1);
        vecs[11] = mk(1, 0, 4'hB, 0, 1, 0, 0, 0, -1);
        vecs[12] = mk(1, 3, 4'hB, 0, 1, 0, 0, 0, -1);
        vecs[13] = mk(0, 3, 4'hB, 0, 1, 0, 0, 0, -1);
        vecs[14] = mk(0, 3, 4'hF, 0, 1, 1, 0, 0, -1);
        vecs[15] = mk(0, 3, 4'hF, 0, 0, 0, 0, 0, -1);

        // reset state
        #13;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
        chk("rst_cnt", 64'(cnt_out), 64'(0));
        chk("rst_slots", 64'(clause_out), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            start_i  = vecs[i].start;
            num_i    = vecs[i].num;
            idle_i   = vecs[i].idle;
            accept_i = vecs[i].acc;
            @(posedge clk); #1;
            s0_exp = (vecs[i].slot0 < 0) ? '0 : mem[vecs[i].slot0];
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].done));
            chk($sformatf("vec%0d_rd_en", i), 64'(mem_rd_en), 64'(vecs[i].rd));
            chk($sformatf("vec%0d_cnt", i), 64'(cnt_out), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_slot0", i), 64'(clause_out[CLA_W-1:0]), 64'(s0_exp));
        end
        start_i = 1'b0;

        for (int i = 0; i < 64; i++) mem[i] = 15'($urandom);

        // backpressure: reads must stop at FIFO_DEPTH buffered clauses
        start_pass(12);
        repeat (20) tick(0, 4'hF);
        chk("bp_reads_stalled", 64'(issued), 64'(FD));
        chk("bp_cnt_out", 64'(cnt_out), 64'(NE));
        run_to_done(1, 200);

        // one clause accepted per cycle
        start_pass(10);
        run_to_done(2, 200);

        // abort the cycle after a read issue
        start_pass(10);
        tick(0, 4'hF);
        mon = 0; in_pass = 0;
        abort_i = 1'b1;
        tick(0, 4'hF);
        abort_i = 1'b0;
        chk("abort_cnt", 64'(cnt_out), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_rd_en", 64'(mem_rd_en), 64'(0));
        tick(0, 4'hF);
        chk("abort_late_data_dropped", 64'(cnt_out), 64'(0));
        chk("abort_no_done", 64'(done), 64'(0));
        start_pass(3);
        run_to_done(1, 200);

        // reset asserted while draining
        start_pass(6);
        waitc = 0;
        while (!(issued == 6 && !mem_rd_en) && waitc < 50) begin
            tick(0, 4'hF);
            waitc++;
        end
        chk("drain_reached", 64'(issued), 64'(6));
        #2 rst_n = 1'b0;
        #1;
        mon = 0; in_pass = 0;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_rd_en", 64'(mem_rd_en), 64'(0));
        chk("arst_cnt", 64'(cnt_out), 64'(0));
        chk("arst_slots", 64'(clause_out), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tick(0, 4'hF);
        chk("arst_idle_after", 64'(busy), 64'(0));
        start_pass(4);
        run_to_done(1, 200);

        // random passes, including the full-memory boundary
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) mem[i] = 15'($urandom);
            start_pass((p == 0) ? 64 : ((p == 1) ? 0 : int'($urandom_range(0, 64))));
            run_to_done(0, 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
